carregador_instrucao: RTL and testbench

CARREGADOR_INSTRUCAO -- requirements
Module: carregador_instrucao

---
 rtl/carregador_instrucao.sv | 179 +++++++++++++++++
 tb/tb_carregador_instrucao.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_instrucao.sv
// carregador_instrucao
//
// Loads a program into a word-wide instruction memory from a byte stream.
// Bytes arrive least-significant first and are packed four to a word. Each
// complete word is written to the next address. If the source signals the end
// of the program early, any partial word is written with its missing upper
// bytes at zero. The rest of the memory is then filled with zero words, so
// every address is written exactly once per load.
//
// Ports
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   inicio        start pulse, honoured only while idle
//   byte_valido   source has a byte on byte_dado
//   byte_dado     program byte
//   fim           end-of-program pulse, honoured only while receiving
//   byte_pronto   loader accepts a byte this cycle
//   escrita_en    one-cycle write strobe to instruction memory
//   escrita_end   word address being written (0 when not writing)
//   escrita_dado  word being written (0 when not writing)
//   ocupado       high whenever a load is in progress
//   concluido     one-cycle pulse when the load has finished
module carregador_instrucao #(
    parameter int PALAVRAS = 64,
    parameter int LARG_END = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inicio,
    input  logic                byte_valido,
    input  logic [7:0]          byte_dado,
    input  logic                fim,
    output logic                byte_pronto,
    output logic                escrita_en,
    output logic [LARG_END-1:0] escrita_end,
    output logic [31:0]         escrita_dado,
    output logic                ocupado,
    output logic                concluido
);

    typedef enum logic [2:0] {
        OCIOSO,
        RECEBENDO,
        ESCREVENDO,
        PREENCHENDO,
        CONCLUIDO
    } estado_t;

    localparam logic [LARG_END-1:0] ULTIMO = LARG_END'(PALAVRAS - 1);

    estado_t             estado;
    logic [LARG_END-1:0] endereco;
    logic [1:0]          contador;
    logic [31:0]         montagem;
    logic                parcial;
    logic                aceita;
    logic [31:0]         montagem_nova;

    // byte_pronto is high only in RECEBENDO, so a handshake implies that state.
    assign aceita = byte_pronto & byte_valido;

    // The assembly register is cleared before each word, so OR-ing the new
    // byte into its lane is enough; unfilled upper lanes stay zero.
    assign montagem_nova = montagem | ({24'd0, byte_dado} << {contador, 3'b000});

    // Single state machine. All outputs are registered: each transition
    // loads the output values that belong to the state being entered. The
    // defaults at the top describe an idle, non-writing cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado       <= OCIOSO;
            endereco     <= '0;
            contador     <= '0;
            montagem     <= '0;
            parcial      <= 1'b0;
            byte_pronto  <= 1'b0;
            escrita_en   <= 1'b0;
            escrita_end  <= '0;
            escrita_dado <= '0;
            ocupado      <= 1'b0;
            concluido    <= 1'b0;
        end else begin
            byte_pronto  <= 1'b0;
            escrita_en   <= 1'b0;
            escrita_end  <= '0;
            escrita_dado <= '0;
            concluido    <= 1'b0;
            ocupado      <= 1'b1;

            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        estado      <= RECEBENDO;
                        endereco    <= '0;
                        contador    <= '0;
                        montagem    <= '0;
                        parcial     <= 1'b0;
                        byte_pronto <= 1'b1;
                    end else begin
                        ocupado <= 1'b0;
                    end
                end

                RECEBENDO: begin
                    if (aceita && (contador == 2'd3 || fim)) begin
                        // Word complete, or last byte arrives together with fim:
                        // include this byte in the word being written.
                        estado       <= ESCREVENDO;
                        montagem     <= montagem_nova;
                        contador     <= contador + 2'd1;
                        parcial      <= fim;
                        escrita_en   <= 1'b1;
                        escrita_end  <= endereco;
                        escrita_dado <= montagem_nova;
                    end else if (aceita) begin
                        montagem    <= montagem_nova;
                        contador    <= contador + 2'd1;
                        byte_pronto <= 1'b1;
                    end else if (fim && contador != 2'd0) begin
                        estado       <= ESCREVENDO;
                        parcial      <= 1'b1;
                        escrita_en   <= 1'b1;
                        escrita_end  <= endereco;
                        escrita_dado <= montagem;
                    end else if (fim) begin
                        // Nothing pending: start zero-filling at the current address.
                        estado      <= PREENCHENDO;
                        escrita_en  <= 1'b1;
                        escrita_end <= endereco;
                    end else begin
                        byte_pronto <= 1'b1;
                    end
                end

                ESCREVENDO: begin
                    contador <= '0;
                    montagem <= '0;
                    if (endereco == ULTIMO) begin
                        // Address is held at the last word so it never leaves range.
                        estado    <= CONCLUIDO;
                        concluido <= 1'b1;
                    end else begin
                        endereco <= endereco + 1'b1;
                        if (parcial) begin
                            estado      <= PREENCHENDO;
                            escrita_en  <= 1'b1;
                            escrita_end <= endereco + 1'b1;
                        end else begin
                            estado      <= RECEBENDO;
                            byte_pronto <= 1'b1;
                        end
                    end
                end

                PREENCHENDO: begin
                    if (endereco == ULTIMO) begin
                        estado    <= CONCLUIDO;
                        concluido <= 1'b1;
                    end else begin
                        endereco    <= endereco + 1'b1;
                        escrita_en  <= 1'b1;
                        escrita_end <= endereco + 1'b1;
                    end
                end

                CONCLUIDO: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end

                default: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_instrucao.sv
// tb_carregador_instrucao
//
// Self-checking bench for carregador_instrucao. The driver records every byte
// the loader actually accepts. The compare process derives each expected
// memory word from that byte list: word a is made of bytes 4a..4a+3,
// least-significant byte first, and any byte never sent reads as zero. It
// also checks the control outputs every cycle.
module tb_carregador_instrucao;

    localparam int PALAVRAS = 64;
    localparam int LARG_END = 6;

    logic                clk         = 1'b0;
    logic                reset_n     = 1'b1;
    logic                inicio      = 1'b0;
    logic                byte_valido = 1'b0;
    logic [7:0]          byte_dado   = 8'd0;
    logic                fim         = 1'b0;
    logic                byte_pronto;
    logic                escrita_en;
    logic [LARG_END-1:0] escrita_end;
    logic [31:0]         escrita_dado;
    logic                ocupado;
    logic                concluido;

    int         total     = 0;
    int         aprovadas = 0;
    logic [7:0] recebidos[$];
    logic [31:0] memoria[PALAVRAS];
    bit         carga_ativa = 1'b0;
    bit         prev_ultima = 1'b0;
    int         prox_end    = 0;
    int         escritas    = 0;

    carregador_instrucao #(
        .PALAVRAS(PALAVRAS),
        .LARG_END(LARG_END)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .inicio      (inicio),
        .byte_valido (byte_valido),
        .byte_dado   (byte_dado),
        .fim         (fim),
        .byte_pronto (byte_pronto),
        .escrita_en  (escrita_en),
        .escrita_end (escrita_end),
        .escrita_dado(escrita_dado),
        .ocupado     (ocupado),
        .concluido   (concluido)
    );

    always #5 clk = ~clk;

    // One comparison: count it, and report it if it does not match.
    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual === esperado) aprovadas++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
    endtask

    // Word a: bytes 4a..4a+3 of the accepted stream, LSB first; missing bytes are zero.
    function automatic logic [31:0] palavra_esperada(input int a);
        logic [31:0] p;
        p = 32'd0;
        for (int j = 0; j < 4; j++)
            if (4 * a + j < recebidos.size()) p[8*j +: 8] = recebidos[4 * a + j];
        return p;
    endfunction

    // Every-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("reset_controle", 32'({byte_pronto, escrita_en, ocupado, concluido}), 32'd0);
            checkOutput("reset_dados", escrita_dado | 32'(escrita_end), 32'd0);
            carga_ativa = 1'b0;
            prev_ultima = 1'b0;
            prox_end    = 0;
            escritas    = 0;
        end else begin
            checkOutput("ocupado", 32'(ocupado), 32'(carga_ativa));
            if (escrita_en) begin
                checkOutput("escrita_em_carga", 32'(carga_ativa), 32'd1);
                checkOutput("escrita_end", 32'(escrita_end), 32'(prox_end));
                checkOutput("escrita_dado", escrita_dado, palavra_esperada(prox_end));
                checkOutput("pronto_durante_escrita", 32'(byte_pronto), 32'd0);
                memoria[escrita_end] = escrita_dado;
                prox_end++;
                escritas++;
            end else begin
                checkOutput("end_sem_escrita", 32'(escrita_end), 32'd0);
                checkOutput("dado_sem_escrita", escrita_dado, 32'd0);
            end
            checkOutput("concluido", 32'(concluido), 32'(prev_ultima));
            if (concluido) begin
                checkOutput("escritas_no_concluido", 32'(escritas), 32'(PALAVRAS));
                carga_ativa = 1'b0;
            end
            prev_ultima = escrita_en && (32'(escrita_end) == 32'(PALAVRAS - 1));
        end
    end

    task automatic iniciarCarga();
        @(negedge clk);
        inicio = 1'b1;
        recebidos.delete();
        prox_end = 0;
        escritas = 0;
        foreach (memoria[i]) memoria[i] = 32'hdeadbeef;
        @(posedge clk);
        carga_ativa = 1'b1;
        #1 inicio = 1'b0;
    endtask

    // Present one byte (optionally with fim/inicio) and hold it until accepted.
    task automatic applyStimulus(input logic [7:0] b, input bit com_fim, input bit com_inicio, input int folga);
        bit aceito;
        aceito = 1'b0;
        repeat ($urandom_range(0, folga)) @(negedge clk);
        for (int c = 0; c < 20 && !aceito; c++) begin
            @(negedge clk);
            byte_valido = 1'b1;
            byte_dado   = b;
            fim         = com_fim;
            inicio      = com_inicio;
            if (byte_pronto) begin
                recebidos.push_back(b);
                aceito = 1'b1;
            end
        end
        checkOutput("byte_aceito", 32'(aceito), 32'd1);
        @(posedge clk);
        #1;
        byte_valido = 1'b0;
        fim         = 1'b0;
        inicio      = 1'b0;
    endtask

    task automatic aplicarFim();
        bit feito;
        feito = 1'b0;
        for (int c = 0; c < 20 && !feito; c++) begin
            @(negedge clk);
            fim = 1'b1;
            if (byte_pronto) feito = 1'b1;
        end
        checkOutput("fim_aceito", 32'(feito), 32'd1);
        @(posedge clk);
        #1 fim = 1'b0;
    endtask

    task automatic aguardarConclusao();
        for (int c = 0; c < 1000 && carga_ativa; c++) @(negedge clk);
        @(negedge clk);
        checkOutput("carga_concluida", 32'(carga_ativa), 32'd0);
        checkOutput("escritas_por_carga", 32'(escritas), 32'(PALAVRAS));
    endtask

    task automatic cargaAleatoria();
        int n;
        bit junto;
        n     = $urandom_range(0, 4 * PALAVRAS);
        junto = 1'($urandom_range(0, 1));
        iniciarCarga();
        for (int i = 0; i < n; i++)
            applyStimulus(8'($urandom), junto && (i == n - 1), 1'b0, 2);
        if (n == 0 || (!junto && n < 4 * PALAVRAS)) aplicarFim();
        aguardarConclusao();
    endtask

    initial begin
        int sujas;
        #1 reset_n = 1'b0;
        #2;
        checkOutput("rst_byte_pronto", 32'(byte_pronto), 32'd0);
        checkOutput("rst_escrita_en", 32'(escrita_en), 32'd0);
        checkOutput("rst_escrita_end", 32'(escrita_end), 32'd0);
        checkOutput("rst_escrita_dado", escrita_dado, 32'd0);
        checkOutput("rst_ocupado", 32'(ocupado), 32'd0);
        checkOutput("rst_concluido", 32'(concluido), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // fim and a byte offered while idle must be ignored
        @(negedge clk);
        fim         = 1'b1;
        byte_valido = 1'b1;
        byte_dado   = 8'haa;
        repeat (3) @(negedge clk);
        checkOutput("ocioso_pronto", 32'(byte_pronto), 32'd0);
        checkOutput("ocioso_ocupado", 32'(ocupado), 32'd0);
        fim         = 1'b0;
        byte_valido = 1'b0;

        // Full load, word n = {n,n,n,n}, no gaps so bytes wait through each write;
        // a stray inicio mid-stream must not disturb it
        $display("[TB] full load");
        iniciarCarga();
        for (int n = 0; n < PALAVRAS; n++)
            for (int k = 0; k < 4; k++)
                applyStimulus(8'(n), 1'b0, (n == 9 && k == 2), 0);
        aguardarConclusao();
        checkOutput("cheia_end0", memoria[0], 32'h00000000);
        checkOutput("cheia_end10", memoria[10], 32'h0a0a0a0a);
        checkOutput("cheia_end63", memoria[63], 32'h3f3f3f3f);

        // Byte order
        $display("[TB] byte order");
        iniciarCarga();
        applyStimulus(8'h13, 1'b0, 1'b0, 1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1);
        applyStimulus(8'h50, 1'b0, 1'b0, 1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1);
        aplicarFim();
        aguardarConclusao();
        checkOutput("ordem_end0", memoria[0], 32'h00500013);
        checkOutput("ordem_end1", memoria[1], 32'h00000000);

        // Early fim after six bytes
        $display("[TB] early fim");
        iniciarCarga();
        for (int i = 1; i <= 6; i++) applyStimulus(8'(i), 1'b0, 1'b0, 1);
        aplicarFim();
        aguardarConclusao();
        checkOutput("curta_end0", memoria[0], 32'h04030201);
        checkOutput("curta_end1", memoria[1], 32'h00000605);
        sujas = 0;
        for (int i = 2; i < PALAVRAS; i++) if (memoria[i] !== 32'd0) sujas++;
        checkOutput("curta_preenchimento", 32'(sujas), 32'd0);

        // Reset in the middle of a load
        $display("[TB] reset mid-load");
        iniciarCarga();
        for (int i = 0; i < 10; i++) applyStimulus(8'(8'hc0 + i), 1'b0, 1'b0, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_meio_pronto", 32'(byte_pronto), 32'd0);
        checkOutput("rst_meio_ocupado", 32'(ocupado), 32'd0);
        checkOutput("rst_meio_escrita", 32'(escrita_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_meio_sem_escritas", 32'(escritas), 32'd0);

        // Randomized loads, the first one restarting after the reset
        $display("[TB] random loads");
        for (int r = 0; r < 6; r++) cargaAleatoria();

        $display("%0d/%0d checks passed", aprovadas, total);
        $finish;
    end

endmodule
